// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared segment constants, BCD-to-7-segment lookup and the
//            display-controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Active-low segment patterns, bit order {G,F,E,D,C,B,A}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        SHOW      = 2'd0,
        FLASH_OFF = 2'd1,
        FLASH_ON  = 2'd2
    } state_e;

    // Digits above 9 are not valid BCD and render as a single dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_bcd_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_bcd_decode
// Brief    : Combinational 4-bit digit to active-low 7-segment decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_Digit,
    output logic [6:0] o_Seg
);

    assign o_Seg = bcd_to_seg(i_Digit);

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : seg7_bcd_display
// Brief    : Two-digit BCD to 7-segment display driver with leading-zero
//            blanking, invalid-digit dash and a flash sequence on wrap to 00.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_bcd_display
    import seg7_pkg::*;
#(
    parameter int CLKS_PER_BLINK     = 6250000,
    parameter int BLINK_COUNT        = 3,
    parameter int LEADING_ZERO_BLANK = 1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Digit_Tens,
    input  logic [3:0] i_Digit_Ones,
    output logic [6:0] o_Seg_Tens,
    output logic [6:0] o_Seg_Ones,
    output logic       o_Digit_Err,
    output logic       o_Flashing
);

    // A one-cycle half-period would give a zero-width timer; keep one bit
    localparam int TMR_W  = (CLKS_PER_BLINK > 1) ? $clog2(CLKS_PER_BLINK) : 1;
    localparam int PAIR_W = $clog2(BLINK_COUNT + 1);
    localparam logic [TMR_W-1:0]  C_TMR_LAST   = TMR_W'(CLKS_PER_BLINK - 1);
    localparam logic [PAIR_W-1:0] C_PAIR_TOTAL = PAIR_W'(BLINK_COUNT);

    logic [3:0]        r_tens_q,  r_ones_q;
    state_e            r_state_q, r_state_d;
    logic [TMR_W-1:0]  r_timer_q, r_timer_d;
    logic [PAIR_W-1:0] r_pair_q,  r_pair_d;
    logic [6:0]        r_seg_tens_q, r_seg_ones_q;
    logic              r_err_q, r_flash_q;

    logic [6:0]        w_dec_tens, w_dec_ones;
    logic [6:0]        w_seg_tens_d, w_seg_ones_d;
    logic              w_wrap;
    logic [PAIR_W-1:0] w_pair_inc;

    seg7_bcd_decode u_dec_tens (
        .i_Digit (r_tens_q),
        .o_Seg   (w_dec_tens)
    );

    seg7_bcd_decode u_dec_ones (
        .i_Digit (r_ones_q),
        .o_Seg   (w_dec_ones)
    );

    // Wrap = incoming 00 while the previously captured pair was non-zero,
    // so 00 straight out of reset or a held 00 never triggers a flash
    assign w_wrap     = (i_Digit_Tens == 4'd0) && (i_Digit_Ones == 4'd0) &&
                        ((r_tens_q != 4'd0) || (r_ones_q != 4'd0));
    assign w_pair_inc = r_pair_q + 1'b1;

    // Flash sequencer: next state, half-period timer and pair counter
    always_comb begin
        r_state_d = r_state_q;
        r_timer_d = r_timer_q;
        r_pair_d  = r_pair_q;
        if (w_wrap) begin
            r_state_d = FLASH_OFF;
            r_timer_d = '0;
            r_pair_d  = '0;
        end else begin
            case (r_state_q)
                SHOW: begin
                    r_timer_d = '0;
                    r_pair_d  = '0;
                end
                FLASH_OFF: begin
                    if (r_timer_q == C_TMR_LAST) begin
                        r_state_d = FLASH_ON;
                        r_timer_d = '0;
                    end else begin
                        r_timer_d = r_timer_q + 1'b1;
                    end
                end
                FLASH_ON: begin
                    if (r_timer_q == C_TMR_LAST) begin
                        r_timer_d = '0;
                        if (w_pair_inc == C_PAIR_TOTAL) begin
                            r_state_d = SHOW;
                            r_pair_d  = '0;
                        end else begin
                            r_state_d = FLASH_OFF;
                            r_pair_d  = w_pair_inc;
                        end
                    end else begin
                        r_timer_d = r_timer_q + 1'b1;
                    end
                end
                default: begin
                    r_state_d = SHOW;
                    r_timer_d = '0;
                    r_pair_d  = '0;
                end
            endcase
        end
    end

    // Segment selection: flash-off blanking, then leading-zero blank, then decode
    always_comb begin
        w_seg_tens_d = w_dec_tens;
        w_seg_ones_d = w_dec_ones;
        if (r_state_q == FLASH_OFF) begin
            w_seg_tens_d = SEG_BLANK;
            w_seg_ones_d = SEG_BLANK;
        end else if ((LEADING_ZERO_BLANK != 0) && (r_tens_q == 4'd0)) begin
            w_seg_tens_d = SEG_BLANK;
        end
    end

    // Capture stage and sequencer state
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_tens_q  <= 4'd0;
            r_ones_q  <= 4'd0;
            r_state_q <= SHOW;
            r_timer_q <= '0;
            r_pair_q  <= '0;
        end else begin
            r_tens_q  <= i_Digit_Tens;
            r_ones_q  <= i_Digit_Ones;
            r_state_q <= r_state_d;
            r_timer_q <= r_timer_d;
            r_pair_q  <= r_pair_d;
        end
    end

    // Output stage, one cycle behind capture
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_seg_tens_q <= SEG_BLANK;
            r_seg_ones_q <= SEG_BLANK;
            r_err_q      <= 1'b0;
            r_flash_q    <= 1'b0;
        end else begin
            r_seg_tens_q <= w_seg_tens_d;
            r_seg_ones_q <= w_seg_ones_d;
            r_err_q      <= (r_tens_q > 4'd9) || (r_ones_q > 4'd9);
            r_flash_q    <= (r_state_q != SHOW);
        end
    end

    assign o_Seg_Tens  = r_seg_tens_q;
    assign o_Seg_Ones  = r_seg_ones_q;
    assign o_Digit_Err = r_err_q;
    assign o_Flashing  = r_flash_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_bcd_display
// Brief    : Scoreboard bench for seg7_bcd_display (blank and no-blank builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_bcd_display;

    localparam int CPB   = 4;
    localparam int BC    = 2;
    localparam int TOTAL = 2 * BC * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;

    logic [6:0] seg_tens, seg_ones, nz_tens, nz_ones;
    logic       err, flash, nz_err, nz_flash;

    seg7_bcd_display #(
        .CLKS_PER_BLINK     (CPB),
        .BLINK_COUNT        (BC),
        .LEADING_ZERO_BLANK (1)
    ) u_dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Digit_Tens (tens),
        .i_Digit_Ones (ones),
        .o_Seg_Tens   (seg_tens),
        .o_Seg_Ones   (seg_ones),
        .o_Digit_Err  (err),
        .o_Flashing   (flash)
    );

    seg7_bcd_display #(
        .CLKS_PER_BLINK     (CPB),
        .BLINK_COUNT        (BC),
        .LEADING_ZERO_BLANK (0)
    ) u_dut_nz (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Digit_Tens (tens),
        .i_Digit_Ones (ones),
        .o_Seg_Tens   (nz_tens),
        .o_Seg_Ones   (nz_ones),
        .o_Digit_Err  (nz_err),
        .o_Flashing   (nz_flash)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] tens;
        logic [6:0] ones;
        logic [6:0] tens_nz;
        logic       err;
        logic       fl;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference model: captured pair and remaining flash cycles
    logic [3:0] m_t = 4'd0;
    logic [3:0] m_o = 4'd0;
    int         m_left = 0;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   elapsed;
        logic blank;
        elapsed   = TOTAL - m_left;
        blank     = (m_left > 0) && (((elapsed / CPB) % 2) == 0);
        e.fl      = (m_left > 0);
        e.err     = (m_t > 4'd9) || (m_o > 4'd9);
        e.ones    = blank ? 7'h7F : ref_seg(m_o);
        e.tens_nz = blank ? 7'h7F : ref_seg(m_t);
        e.tens    = (blank || m_t == 4'd0) ? 7'h7F : ref_seg(m_t);
        return e;
    endfunction

    task automatic check_eq(input string tag, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] t, input logic [3:0] o, input logic r);
        exp_t e;
        logic wrap;
        @(negedge clk);
        tens = t;
        ones = o;
        rst  = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_t    = 4'd0;
            m_o    = 4'd0;
            m_left = 0;
            sb.delete();
            sb.push_back(model_out());
            #1;
            check_eq("rst_tens",  seg_tens, 7'h7F);
            check_eq("rst_ones",  seg_ones, 7'h7F);
            check_eq("rst_err",   {6'd0, err},   7'd0);
            check_eq("rst_flash", {6'd0, flash}, 7'd0);
            check_eq("rst_nz_tens", nz_tens, 7'h7F);
        end else begin
            wrap = (t == 4'd0) && (o == 4'd0) && ((m_t != 4'd0) || (m_o != 4'd0));
            m_t  = t;
            m_o  = o;
            if (wrap)
                m_left = TOTAL;
            else if (m_left > 0)
                m_left--;
            sb.push_back(model_out());
            #1;
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                check_eq("seg_tens",   seg_tens, e.tens);
                check_eq("seg_ones",   seg_ones, e.ones);
                check_eq("digit_err",  {6'd0, err},   {6'd0, e.err});
                check_eq("flashing",   {6'd0, flash}, {6'd0, e.fl});
                check_eq("nz_seg_tens", nz_tens, e.tens_nz);
                check_eq("nz_seg_ones", nz_ones, e.ones);
            end
        end
    endtask

    task automatic hold(input logic [3:0] t, input logic [3:0] o, input int n);
        for (int i = 0; i < n; i++) step(t, o, 1'b0);
    endtask

    initial begin
        // Reset, then 00: tens blanked, ones shows 0, no flash
        step(4'd0, 4'd0, 1'b1);
        step(4'd0, 4'd0, 1'b1);
        hold(4'd0, 4'd0, 4);

        // Plain counting steps
        hold(4'd0, 4'd7, 3);
        hold(4'd1, 4'd5, 4);

        // Wrap to 00: full flash, then a steady 00 must not re-trigger
        hold(4'd0, 4'd0, TOTAL + 8);

        // Second wrap inside a running flash restarts the sequence
        hold(4'd1, 4'd5, 2);
        hold(4'd0, 4'd0, 4);
        step(4'd0, 4'd3, 1'b0);
        hold(4'd0, 4'd0, TOTAL + 6);

        // Invalid digit shows a dash and raises the error flag
        hold(4'd1, 4'd12, 4);
        hold(4'd1, 4'd2, 4);
        hold(4'd15, 4'd10, 3);

        // Reset during FLASH_OFF, then 00 after release must not flash
        hold(4'd2, 4'd1, 2);
        hold(4'd0, 4'd0, 2);
        step(4'd0, 4'd0, 1'b1);
        hold(4'd0, 4'd0, 6);
        hold(4'd9, 4'd9, 3);

        // Random traffic with frequent wraps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0)
                step(4'd0, 4'd0, 1'b0);
            else
                step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
        end
        hold(4'd0, 4'd0, TOTAL + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
